// File: rtl/jk_state_decoder.sv
// Receive-side decoder for the two-flop JK machine: recovers input bits
// from the sampled state stream and packs them into handshaked words.
module jk_state_decoder #(
  parameter int WORD_W     = 8,
  parameter int ERR_CNT_W  = 8,
  parameter int RESYNC_LEN = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           st_in,
  input  logic                 st_vld,
  output logic                 bit_out,
  output logic                 bit_vld,
  output logic                 bit_amb,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 locked,
  output logic [WORD_W-1:0]    word_out,
  output logic                 word_vld,
  input  logic                 word_rdy,
  output logic                 overflow
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int RS_W  = $clog2(RESYNC_LEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOCK = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [RS_W-1:0]  RS_DONE  = RS_W'(RESYNC_LEN);

  logic [1:0]        fsm;
  logic [1:0]        prev;
  logic [IDX_W-1:0]  idx;
  logic [RS_W-1:0]   rs_cnt;
  logic [WORD_W-1:0] asm_r;

  logic [3:0]        pair;
  logic              dec;
  logic              amb;
  logic              ill;
  logic              xbit;
  logic [WORD_W-1:0] asm_nxt;
  logic              done;
  logic [RS_W-1:0]   rs_nxt;

  assign pair = {prev, st_in};

  always_comb begin
    dec  = 1'b0;
    amb  = 1'b0;
    xbit = 1'b0;
    unique case (1'b1)
      (pair == 4'b0000),
      (pair == 4'b0100): dec = 1'b1;
      (pair == 4'b0011),
      (pair == 4'b0110): begin
        dec  = 1'b1;
        xbit = 1'b1;
      end
      (pair == 4'b1010),
      (pair == 4'b1110): amb = 1'b1;
      default: ;
    endcase
  end

  assign ill = !dec && !amb;

  always_comb begin
    asm_nxt      = asm_r;
    asm_nxt[idx] = xbit;
  end

  assign done   = st_vld && (fsm == S_LOCK) && dec && (idx == IDX_LAST);
  assign rs_nxt = rs_cnt + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm       <= S_IDLE;
      prev      <= 2'b00;
      idx       <= '0;
      rs_cnt    <= '0;
      asm_r     <= '0;
      bit_out   <= 1'b0;
      bit_vld   <= 1'b0;
      bit_amb   <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      locked    <= 1'b0;
      word_out  <= '0;
      word_vld  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      bit_out   <= 1'b0;
      bit_vld   <= 1'b0;
      bit_amb   <= 1'b0;
      err_pulse <= 1'b0;
      if (word_vld && word_rdy) word_vld <= 1'b0;
      if (st_vld) begin
        prev <= st_in;
        unique case (fsm)
          S_IDLE: begin
            fsm    <= S_LOCK;
            locked <= 1'b1;
          end
          S_LOCK: begin
            if (dec) begin
              bit_vld <= 1'b1;
              bit_out <= xbit;
              asm_r   <= asm_nxt;
              idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else if (amb) begin
              bit_amb <= 1'b1;
            end else begin
              err_pulse <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
              idx    <= '0;
              rs_cnt <= '0;
              fsm    <= S_ERR;
              locked <= 1'b0;
            end
          end
          S_ERR: begin
            if (ill) begin
              err_pulse <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
              rs_cnt <= '0;
            end else if (rs_nxt == RS_DONE) begin
              rs_cnt <= '0;
              fsm    <= S_LOCK;
              locked <= 1'b1;
            end else begin
              rs_cnt <= rs_nxt;
            end
          end
          default: begin
            fsm    <= S_IDLE;
            locked <= 1'b0;
          end
        endcase
      end
      // a full holding register that is not draining drops the new word
      if (done) begin
        if (word_vld && !word_rdy) begin
          overflow <= 1'b1;
        end else begin
          word_out <= asm_nxt;
          word_vld <= 1'b1;
        end
      end
    end
  end

endmodule
